// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b line/word types and pmem responder constants
package lc3b_types;

  typedef logic [127:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;

  localparam int PMEM_LINE_OFFSET = 4;

  typedef enum logic [1:0] {
    PMEM_IDLE = 2'd0,
    PMEM_BUSY = 2'd1,
    PMEM_RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - single-port line array, registered read, synchronous write
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  lc3b_block            wdata,
  output lc3b_block            rdata
);

  lc3b_block mem [0:(1<<ADDR_BITS)-1];
  lc3b_block rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  // Read register holds its value between reads; only it is reset, not the array.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency pmem line responder; PMEM_CHECK_EN adds sticky protocol checker
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LINE_ADDR_BITS = 12,
  parameter int LATENCY        = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [15:0] pmem_address,
  input  lc3b_block   pmem_wdata,
  output lc3b_block   pmem_rdata,
  output logic        pmem_resp,
  output logic        pmem_err
);

  localparam int IDX_HI = LINE_ADDR_BITS + PMEM_LINE_OFFSET - 1;

  pmem_state_e               state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [LINE_ADDR_BITS-1:0] idx_q, idx_d;
  logic                      op_wr_q, op_wr_d;
  lc3b_block                 wdata_q, wdata_d;

  logic                      arr_rd_en, arr_wr_en;
  logic [LINE_ADDR_BITS-1:0] arr_addr;
  logic                      req;
  logic                      unused_addr_bits;

  assign req              = pmem_read | pmem_write;
  assign unused_addr_bits = ^pmem_address[PMEM_LINE_OFFSET-1:0];

  // The array read is issued in the cycle before RESP so rdata lands on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    op_wr_d   = op_wr_q;
    wdata_d   = wdata_q;
    pmem_resp = 1'b0;
    arr_rd_en = 1'b0;
    arr_wr_en = 1'b0;
    arr_addr  = idx_q;
    case (state_q)
      PMEM_IDLE: begin
        arr_addr = pmem_address[IDX_HI:PMEM_LINE_OFFSET];
        if (req) begin
          idx_d   = pmem_address[IDX_HI:PMEM_LINE_OFFSET];
          op_wr_d = pmem_write;
          wdata_d = pmem_wdata;
          cnt_d   = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = PMEM_RESP;
            arr_rd_en = !pmem_write;
          end else begin
            state_d = PMEM_BUSY;
          end
        end
      end
      PMEM_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d   = PMEM_RESP;
          arr_rd_en = !op_wr_q;
        end
      end
      PMEM_RESP: begin
        pmem_resp = 1'b1;
        arr_wr_en = op_wr_q;
        state_d   = PMEM_IDLE;
      end
      default: state_d = PMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PMEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_wr_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_wr_q <= op_wr_d;
      wdata_q <= wdata_d;
    end
  end

  pmem_line_array #(.ADDR_BITS(LINE_ADDR_BITS)) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (arr_addr),
    .rd_en   (arr_rd_en),
    .wr_en   (arr_wr_en),
    .wdata   (wdata_q),
    .rdata   (pmem_rdata)
  );

`ifdef PMEM_CHECK_EN
  logic        err_q, err_d;
  logic [11:0] tag_q, tag_d;

  // Tag covers the full [15:4] field, independent of how many index bits the array uses.
  always_comb begin
    err_d = err_q;
    tag_d = tag_q;
    if (state_q == PMEM_IDLE && req) begin
      tag_d = pmem_address[15:PMEM_LINE_OFFSET];
      if (pmem_read && pmem_write) err_d = 1'b1;
    end
    if (state_q == PMEM_BUSY) begin
      if ((op_wr_q && !pmem_write) || (!op_wr_q && !pmem_read) ||
          (pmem_address[15:PMEM_LINE_OFFSET] != tag_q))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      tag_q <= '0;
    end else begin
      err_q <= err_d;
      tag_q <= tag_d;
    end
  end

  assign pmem_err = err_q;
`else
  assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed self-checking bench for pmem_responder (LATENCY 10 and 1)
module tb_pmem_responder;
  import lc3b_types::*;

`ifdef PMEM_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam lc3b_block D_LINE = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam lc3b_block D_AAAA = {8{16'hAAAA}};
  localparam lc3b_block D_5555 = {8{16'h5555}};
  localparam lc3b_block D_0040 = 128'hFEEDFACE_CAFEBABE_DEADBEEF_00400040;
  localparam lc3b_block D_LOST = 128'h11112222_33334444_55556666_77778888;
  localparam lc3b_block D_B    = 128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_read = 0, a_write = 0;
  logic [15:0] a_addr = '0;
  lc3b_block   a_wdata = '0, a_rdata;
  logic        a_resp, a_err;

  logic        b_read = 0, b_write = 0;
  logic [15:0] b_addr = '0;
  lc3b_block   b_wdata = '0, b_rdata;
  logic        b_resp, b_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pmem_responder #(.LINE_ADDR_BITS(12), .LATENCY(10)) dut_a (
    .clk (clk), .reset_n (reset_n),
    .pmem_read (a_read), .pmem_write (a_write), .pmem_address (a_addr),
    .pmem_wdata (a_wdata), .pmem_rdata (a_rdata), .pmem_resp (a_resp), .pmem_err (a_err)
  );

  pmem_responder #(.LINE_ADDR_BITS(12), .LATENCY(1)) dut_b (
    .clk (clk), .reset_n (reset_n),
    .pmem_read (b_read), .pmem_write (b_write), .pmem_address (b_addr),
    .pmem_wdata (b_wdata), .pmem_rdata (b_rdata), .pmem_resp (b_resp), .pmem_err (b_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [15:0] addr, input lc3b_block wd);
    if (sel) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    end
  endtask

  // Called at a negedge in IDLE: that cycle is cycle 0. Returns at the negedge of the cycle after RESP.
  task automatic txn(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                     input lc3b_block wd, input int exp_lat, input lc3b_block exp_rd,
                     input int chg_cycle, input logic [15:0] chg_addr, input string tag);
    int        lat;
    lc3b_block got;
    lat = -1;
    got = '0;
    drive(sel, rd, wr, addr, wd);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == chg_cycle) begin
        if (sel) b_addr = chg_addr; else a_addr = chg_addr;
      end
      if ((sel ? b_resp : a_resp) === 1'b1) begin
        lat = c;
        got = sel ? b_rdata : a_rdata;
      end
    end
    drive(sel, 1'b0, 1'b0, addr, wd);
    check({tag, " resp cycle"}, 128'(lat), 128'(exp_lat));
    check({tag, " rdata"}, got, exp_rd);
    @(negedge clk);
    check({tag, " resp after"}, {127'd0, sel ? b_resp : a_resp}, 128'd0);
  endtask

  initial begin
    int        nresp;
    logic [3:1] hist;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("reset resp", {127'd0, a_resp}, 128'd0);
    check("reset rdata", a_rdata, 128'd0);
    check("reset err", {127'd0, a_err}, 128'd0);

    txn(0, 0, 1, 16'h1230, D_LINE, 10, 128'd0, 0, 16'h0, "wr 1230");
    txn(0, 1, 0, 16'h123F, '0, 10, D_LINE, 0, 16'h0, "rd 123F");
    @(negedge clk);
    check("rdata hold", a_rdata, D_LINE);

    txn(0, 0, 1, 16'h1230, D_AAAA, 10, D_LINE, 0, 16'h0, "wr AAAA");
    txn(0, 1, 0, 16'h1230, '0, 10, D_AAAA, 0, 16'h0, "raw 1230");

    txn(0, 0, 1, 16'h0040, D_0040, 10, D_AAAA, 0, 16'h0, "wr 0040");
    drive(0, 0, 1, 16'h0040, D_LOST);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 16'h0, '0);
    #1;
    check("abort rdata", a_rdata, 128'd0);
    check("abort resp", {127'd0, a_resp}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nresp = 0;
    repeat (15) begin
      @(negedge clk);
      if (a_resp === 1'b1) nresp++;
    end
    check("abort no resp", 128'(nresp), 128'd0);
    txn(0, 1, 0, 16'h0040, '0, 10, D_0040, 0, 16'h0, "rd after abort");

    txn(0, 1, 0, 16'h0040, '0, 10, D_0040, 3, 16'h0080, "addr change");
    check("addr change err", {127'd0, a_err}, {127'd0, CHK});

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("err cleared", {127'd0, a_err}, 128'd0);
    txn(0, 1, 1, 16'h0100, D_5555, 10, 128'd0, 0, 16'h0, "rd+wr 0100");
    check("rd+wr err", {127'd0, a_err}, {127'd0, CHK});
    txn(0, 1, 0, 16'h0100, '0, 10, D_5555, 0, 16'h0, "rd 0100");

    drive(1, 0, 1, 16'h0200, D_B);
    hist = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      hist[c] = b_resp;
    end
    drive(1, 0, 0, 16'h0200, D_B);
    check("lat1 held resp", {125'd0, hist}, 128'b101);
    @(negedge clk);
    check("lat1 resp after", {127'd0, b_resp}, 128'd0);
    txn(1, 1, 0, 16'h0200, '0, 1, D_B, 0, 16'h0, "lat1 rd");
    check("lat1 err", {127'd0, b_err}, 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
